// File: rtl/seven_segment_scan_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_segment_scan_ctrl_if : display-load valid/ready bundle             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface seven_segment_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    loadValid;
  logic                    loadReady;
  logic [4*NUM_DIGITS-1:0] loadValue;
  logic [NUM_DIGITS-1:0]   loadBlank;
  logic                    loadLz;

  modport master (
    output loadValid, loadValue, loadBlank, loadLz,
    input  loadReady
  );

  modport slave (
    input  loadValid, loadValue, loadBlank, loadLz,
    output loadReady
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_segment_scan_ctrl : multiplexed hex display scanner with           |
// | frame-aligned load commit and dead-time between digits                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seven_segment_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  seven_segment_scan_ctrl_if.slave load,
  output logic [6:0]            segOut,
  output logic [NUM_DIGITS-1:0] digitSel,
  output logic                  frameTick
);
  localparam int CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [0:0] {ST_DEAD = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t                  r_state, w_stateNext;
  logic [CW-1:0]           r_cnt, w_cntNext;
  logic [IW-1:0]           r_idx, w_idxNext;
  logic [4*NUM_DIGITS-1:0] r_pendValue, r_dispValue;
  logic [NUM_DIGITS-1:0]   r_pendBlank, r_dispBlank;
  logic                    r_pendLz, r_dispLz, r_pendFlag;
  logic [6:0]              r_segOut, w_segNext;
  logic [NUM_DIGITS-1:0]   r_digitSel, w_selNext;
  logic                    r_frameTick;
  logic                    w_lastDead, w_lastShow, w_frameEnd;
  logic [IW-1:0]           w_msnz;
  logic [3:0]              w_nibble;
  logic                    w_visible;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'b1000000;  4'h1: f_decode = 7'b1111001;
      4'h2: f_decode = 7'b0100100;  4'h3: f_decode = 7'b0110000;
      4'h4: f_decode = 7'b0011001;  4'h5: f_decode = 7'b0010010;
      4'h6: f_decode = 7'b0000010;  4'h7: f_decode = 7'b1111000;
      4'h8: f_decode = 7'b0000000;  4'h9: f_decode = 7'b0010000;
      4'hA: f_decode = 7'b0001000;  4'hB: f_decode = 7'b0000011;
      4'hC: f_decode = 7'b1000110;  4'hD: f_decode = 7'b0100001;
      4'hE: f_decode = 7'b0000110;  default: f_decode = 7'b0001110;
    endcase
  endfunction

  assign w_lastDead = (r_state == ST_DEAD) && (r_cnt == CW'(DEAD_CYCLES - 1));
  assign w_lastShow = (r_state == ST_SHOW) && (r_cnt == CW'(SCAN_DIV - 1));
  assign w_frameEnd = w_lastShow && (r_idx == IW'(NUM_DIGITS - 1));

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt + 1'b1;
    w_idxNext   = r_idx;
    if (w_lastDead) begin
      w_stateNext = ST_SHOW;
      w_cntNext   = '0;
    end else if (w_lastShow) begin
      w_stateNext = ST_DEAD;
      w_cntNext   = '0;
      w_idxNext   = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Outputs are computed from the next state so the registered pins line up with the state.
  always_comb begin
    w_msnz = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_dispValue[i*4 +: 4] != 4'h0) w_msnz = IW'(i);
    end
    w_nibble  = r_dispValue[{w_idxNext, 2'b00} +: 4];
    w_visible = !r_dispBlank[w_idxNext] && !(r_dispLz && (w_idxNext > w_msnz));
    w_selNext = '1;
    w_segNext = 7'h7F;
    if ((w_stateNext == ST_SHOW) && w_visible) begin
      w_selNext[w_idxNext] = 1'b0;
      w_segNext            = f_decode(w_nibble);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_DEAD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pendValue <= '0;
      r_pendBlank <= '0;
      r_pendLz    <= 1'b0;
      r_pendFlag  <= 1'b0;
      r_dispValue <= '0;
      r_dispBlank <= '0;
      r_dispLz    <= 1'b0;
      r_segOut    <= 7'h7F;
      r_digitSel  <= '1;
      r_frameTick <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_idx       <= w_idxNext;
      r_segOut    <= w_segNext;
      r_digitSel  <= w_selNext;
      r_frameTick <= w_frameEnd;
      if (w_frameEnd && r_pendFlag) begin
        r_dispValue <= r_pendValue;
        r_dispBlank <= r_pendBlank;
        r_dispLz    <= r_pendLz;
        r_pendFlag  <= 1'b0;
      end else if (load.loadValid && !r_pendFlag) begin
        r_pendValue <= load.loadValue;
        r_pendBlank <= load.loadBlank;
        r_pendLz    <= load.loadLz;
        r_pendFlag  <= 1'b1;
      end
    end
  end

  assign load.loadReady = !r_pendFlag;
  assign segOut         = r_segOut;
  assign digitSel       = r_digitSel;
  assign frameTick      = r_frameTick;
endmodule
`default_nettype wire

// File: doc/seven_segment_scan_ctrl.md
# seven_segment_scan_ctrl

Time-multiplexed scan controller that shares a single hex-to-seven-segment decode path among NUM_DIGITS common-anode digits. It accepts a display value through a valid/ready handshake and holds it until a frame boundary, so a frame never shows a partial update. It drives the active-low segment bus and the active-low digit selects, inserting a dead interval between digits to suppress ghosting. It sits between the encoder debug/status logic and the board's multiplexed display pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (≥1)
- SCAN_DIV, 1000, clock cycles each digit is lit (≥1)
- DEAD_CYCLES, 16, clock cycles all digits are off before each digit (≥1)
- clock  in  1  single system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- loadValid  in  1  loadValue/loadBlank/loadLz are valid
- loadReady  out  1  controller can accept a new load
- loadValue  in  4*NUM_DIGITS  hex nibbles, digit 0 = bits [3:0] (rightmost)
- loadBlank  in  NUM_DIGITS  per-digit forced blank, 1 = blank
- loadLz  in  1  leading-zero suppression enable
- segOut  out  7  active-low segments, bit0 = a … bit6 = g
- digitSel  out  NUM_DIGITS  active-low one-hot digit enable
- frameTick  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: pending {value, blank, lz} + pendingFlag; displayed {value, blank, lz}; state ∈ {DEAD, SHOW}; digit index idx; phase counter cnt.
- Handshake: loadReady = !pendingFlag. Transfer on rising edge with loadValid && loadReady: capture into pending, set pendingFlag. Inputs are ignored while loadReady=0.
- DEAD: digitSel all 1, segOut 7'h7F; after DEAD_CYCLES cycles → SHOW, cnt=0.
- SHOW: lasts SCAN_DIV cycles. If digit idx is visible: digitSel[idx]=0 and segOut = decode(nibble idx). Otherwise digitSel all 1 and segOut 7'h7F. Timing is unchanged either way. At the end → DEAD, idx = idx+1, wrapping NUM_DIGITS-1 → 0.
- Decode (active-low): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, B→0000011, C→1000110, D→0100001, E→0000110, F→0001110.
- Visibility: a digit is hidden if its displayed blank bit is 1, or if lz=1 and the digit lies above the most significant nonzero nibble. Digit 0 is never lz-suppressed, so a value of 0 shows "0".
- Frame boundary: the edge ending SHOW of idx=NUM_DIGITS-1. On that edge, if pendingFlag, copy pending→displayed and clear pendingFlag. frameTick=1 for the following cycle whether or not a commit occurred.
- Commit and accept never coincide, because loadReady=0 whenever pendingFlag=1.

## Timing
- Reset (async assert): segOut=7'h7F, digitSel all 1, loadReady=1, frameTick=0, pendingFlag=0, displayed value=0, blank=0, lz=0, state=DEAD, idx=0, cnt=0.
- Reset mid-operation: the pending load is discarded and the displayed value returns to 0.
- segOut, digitSel and frameTick are registered, with no combinational path from inputs.
- First SHOW (digit 0) is visible DEAD_CYCLES cycles after resetn deasserts.
- Frame length F = NUM_DIGITS*(DEAD_CYCLES+SCAN_DIV) cycles.
- loadReady falls the cycle after acceptance and rises the cycle after commit (coincident with frameTick).
- Load→display latency: 1 to F cycles, up to the next frame boundary, then DEAD_CYCLES more before digit 0 shows the new value.

## Test plan
Common parameters: NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=2, F=24.

- Reset, no load → every SHOW slot: digitSel 1110/1101/1011/0111 in order, segOut 1000000 for 4 cycles each. Digit 0 is first lit at cycle 2. frameTick fires every 24 cycles.
- Load value=16'h00A3, lz=1 → after commit: digit0 segOut 0110000, digit1 0001000, digits 2–3 digitSel all 1 and segOut 1111111.
- Load 16'h1234 at mid-frame (cycle 10) → the current frame keeps showing old digits 2–3. The new value appears starting with the next frame's digit 0. loadReady is 0 from cycle 11 until the frameTick cycle.
- Back-to-back loads with loadValid held high → the second value is accepted only on the cycle after frameTick. Each value is shown for at least one full frame, and none is dropped or torn.
- Load 16'h1234, blank=4'b0100 → digit 2 is dark (all 1) while digits 0, 1, 3 show 4, 3, 1 (0011001, 0110000, 1111001).
- Assert resetn=0 asynchronously mid-SHOW with a load pending → outputs go to the reset values immediately without waiting for a clock edge. After release, the display shows 0000 and the pending value never appears.
